// File: rtl/cpu_network_interface.sv
// cpu_network_interface
// MEM-stage network interface of the pipelined RV32IMF core. SWNET requests
// are queued into a TX FIFO toward the local router; LWNET requests are served
// from an RX FIFO filled by the router. BUSYWAIT stalls the pipeline whenever a
// request cannot complete in the current cycle.
//
// Ports:
//   CLK        in   core clock, rising edge
//   RESET      in   asynchronous active-low reset
//   NET_WRITE  in   SWNET in MEM
//   NET_READ   in   LWNET in MEM
//   NET_ADDR   in   destination node/neuron address
//   NET_WDATA  in   SWNET payload
//   NET_RDATA  out  LWNET result (0 while RX is empty)
//   BUSYWAIT   out  pipeline stall request
//   TX_VALID   out  TX FIFO head valid
//   TX_READY   in   router accepts the TX head
//   TX_PACKET  out  {dest address, payload} at the TX head
//   RX_VALID   in   router offers a payload
//   RX_READY   out  RX FIFO can accept
//   RX_DATA    in   incoming payload
module cpu_network_interface #(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   NET_WRITE,
    input  logic                   NET_READ,
    input  logic [31:0]            NET_ADDR,
    input  logic [DATA_WIDTH-1:0]  NET_WDATA,
    output logic [DATA_WIDTH-1:0]  NET_RDATA,
    output logic                   BUSYWAIT,
    output logic                   TX_VALID,
    input  logic                   TX_READY,
    output logic [32+DATA_WIDTH-1:0] TX_PACKET,
    input  logic                   RX_VALID,
    output logic                   RX_READY,
    input  logic [DATA_WIDTH-1:0]  RX_DATA
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int PKT_W = 32 + DATA_WIDTH;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    logic [PKT_W-1:0]      txMem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] rxMem_q [FIFO_DEPTH];

    logic [PTR_W-1:0] txRdPtr_q, txRdPtr_d, txWrPtr_q, txWrPtr_d;
    logic [PTR_W-1:0] rxRdPtr_q, rxRdPtr_d, rxWrPtr_q, rxWrPtr_d;
    logic [CNT_W-1:0] txCount_q, txCount_d, rxCount_q, rxCount_d;

    logic txFull, txEmpty, rxFull, rxEmpty;
    logic txPush, txPop, rxPush, rxPop;

    // Full/empty come from registered counts only, so BUSYWAIT never depends
    // combinationally on TX_READY or RX_VALID.
    always_comb begin
        txFull  = (txCount_q == CNT_FULL);
        txEmpty = (txCount_q == '0);
        rxFull  = (rxCount_q == CNT_FULL);
        rxEmpty = (rxCount_q == '0);

        // An illegal decode with both requests high serves the write only.
        txPush = NET_WRITE & ~txFull;
        txPop  = ~txEmpty & TX_READY;
        rxPush = RX_VALID & RX_READY;
        rxPop  = NET_READ & ~NET_WRITE & ~rxEmpty;
    end

    always_comb begin
        txRdPtr_d = txRdPtr_q;
        txWrPtr_d = txWrPtr_q;
        txCount_d = txCount_q;
        rxRdPtr_d = rxRdPtr_q;
        rxWrPtr_d = rxWrPtr_q;
        rxCount_d = rxCount_q;

        if (txPush) txWrPtr_d = txWrPtr_q + PTR_ONE;
        if (txPop)  txRdPtr_d = txRdPtr_q + PTR_ONE;
        case ({txPush, txPop})
            2'b10:   txCount_d = txCount_q + CNT_ONE;
            2'b01:   txCount_d = txCount_q - CNT_ONE;
            default: txCount_d = txCount_q;
        endcase

        if (rxPush) rxWrPtr_d = rxWrPtr_q + PTR_ONE;
        if (rxPop)  rxRdPtr_d = rxRdPtr_q + PTR_ONE;
        case ({rxPush, rxPop})
            2'b10:   rxCount_d = rxCount_q + CNT_ONE;
            2'b01:   rxCount_d = rxCount_q - CNT_ONE;
            default: rxCount_d = rxCount_q;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            txRdPtr_q <= '0;
            txWrPtr_q <= '0;
            txCount_q <= '0;
            rxRdPtr_q <= '0;
            rxWrPtr_q <= '0;
            rxCount_q <= '0;
        end else begin
            txRdPtr_q <= txRdPtr_d;
            txWrPtr_q <= txWrPtr_d;
            txCount_q <= txCount_d;
            rxRdPtr_q <= rxRdPtr_d;
            rxWrPtr_q <= rxWrPtr_d;
            rxCount_q <= rxCount_d;
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge CLK) begin
        if (txPush) txMem_q[txWrPtr_q] <= {NET_ADDR, NET_WDATA};
        if (rxPush) rxMem_q[rxWrPtr_q] <= RX_DATA;
    end

    always_comb begin
        TX_VALID  = ~txEmpty;
        TX_PACKET = txMem_q[txRdPtr_q];
        // RX_READY is held low while reset is asserted.
        RX_READY  = RESET & ~rxFull;
        NET_RDATA = rxEmpty ? '0 : rxMem_q[rxRdPtr_q];
        BUSYWAIT  = 1'b0;
        if (NET_WRITE) begin
            BUSYWAIT = txFull;
        end else if (NET_READ) begin
            BUSYWAIT = rxEmpty;
        end
    end

endmodule

// File: tb/tb_cpu_network_interface.sv
// tb_cpu_network_interface
// Randomized and directed stimulus for cpu_network_interface. Issued SWNETs
// push their expected packet into a scoreboard queue; a negedge monitor keeps a
// queue-level model of both FIFOs and compares every visible output.
module tb_cpu_network_interface;

    localparam int DEPTH = 4;

    logic        CLK;
    logic        RESET;
    logic        NET_WRITE;
    logic        NET_READ;
    logic [31:0] NET_ADDR;
    logic [31:0] NET_WDATA;
    logic [31:0] NET_RDATA;
    logic        BUSYWAIT;
    logic        TX_VALID;
    logic        TX_READY;
    logic [63:0] TX_PACKET;
    logic        RX_VALID;
    logic        RX_READY;
    logic [31:0] RX_DATA;

    cpu_network_interface #(.FIFO_DEPTH(DEPTH), .DATA_WIDTH(32)) dut (
        .CLK(CLK), .RESET(RESET),
        .NET_WRITE(NET_WRITE), .NET_READ(NET_READ),
        .NET_ADDR(NET_ADDR), .NET_WDATA(NET_WDATA), .NET_RDATA(NET_RDATA),
        .BUSYWAIT(BUSYWAIT),
        .TX_VALID(TX_VALID), .TX_READY(TX_READY), .TX_PACKET(TX_PACKET),
        .RX_VALID(RX_VALID), .RX_READY(RX_READY), .RX_DATA(RX_DATA)
    );

    int total = 0;
    int bad   = 0;

    // Scoreboard and reference state
    logic [63:0] txExpQ[$];
    logic [31:0] rxExpQ[$];
    int          txCount = 0;
    int          rxCount = 0;
    bit          lastBusy = 0;
    bit          lastRxAccepted = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic void checkOutput(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Monitor: compares outputs against the model, then advances the model to
    // what the coming rising edge must produce.
    always @(negedge CLK) begin
        bit expBusy, txPush, txPop, rxPush, rxPop;
        if (!RESET) begin
            checkOutput("reset BUSYWAIT", 64'(BUSYWAIT), 64'(0));
            checkOutput("reset TX_VALID", 64'(TX_VALID), 64'(0));
            checkOutput("reset RX_READY", 64'(RX_READY), 64'(0));
            checkOutput("reset NET_RDATA", 64'(NET_RDATA), 64'(0));
            txExpQ.delete();
            rxExpQ.delete();
            txCount = 0;
            rxCount = 0;
            lastBusy = 0;
            lastRxAccepted = 0;
        end else begin
            if (NET_WRITE)     expBusy = (txCount == DEPTH);
            else if (NET_READ) expBusy = (rxCount == 0);
            else               expBusy = 0;
            checkOutput("BUSYWAIT", 64'(BUSYWAIT), 64'(expBusy));
            checkOutput("TX_VALID", 64'(TX_VALID), 64'(txCount > 0));
            checkOutput("RX_READY", 64'(RX_READY), 64'(rxCount < DEPTH));

            txPush = NET_WRITE && (txCount < DEPTH);
            txPop  = (txCount > 0) && TX_READY;
            rxPop  = NET_READ && !NET_WRITE && (rxCount > 0);
            rxPush = RX_VALID && (rxCount < DEPTH);

            if (txCount > 0) begin
                if (txExpQ.size() == 0) begin
                    checkOutput("TX scoreboard underflow", 64'(1), 64'(0));
                end else begin
                    checkOutput("TX_PACKET", TX_PACKET, txExpQ[0]);
                    if (txPop) void'(txExpQ.pop_front());
                end
            end

            if (rxCount == 0) begin
                checkOutput("NET_RDATA empty", 64'(NET_RDATA), 64'(0));
            end else if (rxExpQ.size() == 0) begin
                checkOutput("RX scoreboard underflow", 64'(1), 64'(0));
            end else begin
                checkOutput("NET_RDATA", 64'(NET_RDATA), 64'(rxExpQ[0]));
                if (rxPop) void'(rxExpQ.pop_front());
            end
            if (rxPush) rxExpQ.push_back(RX_DATA);

            txCount = txCount + int'(txPush) - int'(txPop);
            rxCount = rxCount + int'(rxPush) - int'(rxPop);
            lastBusy = expBusy;
            lastRxAccepted = rxPush;
        end
    end

    // Drives one cycle of inputs and returns after the monitor has seen it.
    task automatic applyStimulus(input logic w, input logic r,
                                 input logic [31:0] a, input logic [31:0] d,
                                 input logic txr, input logic rxv,
                                 input logic [31:0] rxd);
        @(posedge CLK);
        #1;
        NET_WRITE = w;
        NET_READ  = r;
        NET_ADDR  = a;
        NET_WDATA = d;
        TX_READY  = txr;
        RX_VALID  = rxv;
        RX_DATA   = rxd;
        @(negedge CLK);
        #1;
    endtask

    task automatic idle(input int n, input logic txr);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, txr, 0, 0);
    endtask

    // Issues one SWNET and holds it while stalled; TX_READY rises after
    // releaseAfter stalled cycles (0 = never).
    task automatic swnet(input logic [31:0] a, input logic [31:0] d,
                         input logic txrIn, input int releaseAfter);
        logic txr;
        int   stalls;
        txr = txrIn;
        stalls = 0;
        txExpQ.push_back({a, d});
        applyStimulus(1, 0, a, d, txr, 0, 0);
        while (lastBusy && stalls < 50) begin
            stalls++;
            if (stalls == releaseAfter) txr = 1;
            applyStimulus(1, 0, a, d, txr, 0, 0);
        end
        if (lastBusy) checkOutput("SWNET stall timeout", 64'(1), 64'(0));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit          curW, curR;
        logic [31:0] curA, curD;
        int          sel, reads, idx, guard;

        RESET = 0; NET_WRITE = 0; NET_READ = 0; NET_ADDR = 0; NET_WDATA = 0;
        TX_READY = 0; RX_VALID = 0; RX_DATA = 0;

        // Power-on reset
        repeat (2) @(negedge CLK);
        @(posedge CLK); #1; RESET = 1;
        @(negedge CLK); #1;

        // Reset in the middle of a TX-full stall
        for (int i = 0; i < DEPTH; i++) swnet(32'h100 + i, 32'hC0DE0000 + i, 0, 0);
        txExpQ.push_back({32'h200, 32'hC0DE00FF});
        applyStimulus(1, 0, 32'h200, 32'hC0DE00FF, 0, 0, 0);
        checkOutput("stall before reset", 64'(lastBusy), 64'(1));
        @(posedge CLK); #1; RESET = 0; #1;
        checkOutput("async reset BUSYWAIT", 64'(BUSYWAIT), 64'(0));
        checkOutput("async reset TX_VALID", 64'(TX_VALID), 64'(0));
        @(negedge CLK);
        @(posedge CLK); #1; RESET = 1; NET_WRITE = 0;
        @(negedge CLK); #1;

        // Single SWNET straight through
        swnet(32'h00000105, 32'hDEADBEEF, 1, 0);
        idle(3, 1);

        // TX full backpressure, data 1..5; router wakes after 3 stalled cycles
        for (int i = 1; i <= 5; i++) swnet(32'h300 + i, i, 0, 3);
        idle(6, 1);

        // LWNET on empty RX, payload arrives after 3 stalled cycles
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 1, 32'h3F800000);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        checkOutput("LWNET wake", 64'(lastBusy), 64'(0));
        idle(1, 0);

        // RX fill, then reads across the pointer wrap while refilling
        for (int i = 1; i <= DEPTH; i++) applyStimulus(0, 0, 0, 0, 0, 1, i);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'hEE);
        reads = 0; idx = 0; guard = 0;
        while (reads < 6 && guard < 40) begin
            guard++;
            applyStimulus(0, 1, 0, 0, 0, idx < 6, 32'hA + idx);
            if (!lastBusy) reads++;
            if (lastRxAccepted) idx++;
        end
        checkOutput("wrap reads done", 64'(reads), 64'(6));
        guard = 0;
        while (rxCount > 0 && guard < 20) begin
            guard++;
            applyStimulus(0, 1, 0, 0, 0, 0, 0);
        end
        idle(1, 0);

        // Simultaneous push and pop with two entries held
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h11);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h22);
        applyStimulus(0, 1, 0, 0, 0, 1, 32'h33);
        checkOutput("simultaneous count", 64'(rxCount), 64'(2));
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        idle(1, 0);

        // Random traffic, stalled requests held stable
        curW = 0; curR = 0; curA = 0; curD = 0;
        for (int c = 0; c < 400; c++) begin
            if (!lastBusy) begin
                sel  = int'($urandom_range(0, 7));
                curW = (sel <= 2) || (sel == 6);
                curR = ((sel >= 3) && (sel <= 5)) || (sel == 6);
                curA = $urandom;
                curD = $urandom;
                if (curW) txExpQ.push_back({curA, curD});
            end
            applyStimulus(curW, curR, curA, curD, ($urandom_range(0, 2) != 0),
                          $urandom_range(0, 1) == 1, $urandom);
        end
        guard = 0;
        while (lastBusy && guard < 50) begin
            guard++;
            applyStimulus(curW, curR, curA, curD, 1, 1, $urandom);
        end
        idle(10, 1);
        checkOutput("TX drained", 64'(txExpQ.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_network_interface.md
# cpu_network_interface

MEM-stage network interface of the pipelined RV32IMF core. It turns SWNET and LWNET requests into NoC traffic. SWNET requests arrive on the data-memory write signals decoded in ID and are queued into a TX FIFO toward the local router. LWNET requests are served from an RX FIFO filled by the router. The block stalls the pipeline through BUSYWAIT whenever a request cannot complete in the current cycle.

## Interface
Parameters:
- FIFO_DEPTH, 4, entries per FIFO; a power of two, minimum 2.
- DATA_WIDTH, 32, payload width.

Ports:
- CLK  in  1  core clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- NET_WRITE  in  1  SWNET in MEM (DATA_MEM_WRITE[2] qualified by the SWNET opcode).
- NET_READ  in  1  LWNET in MEM (DATA_MEM_READ[3] qualified by the LWNET opcode).
- NET_ADDR  in  32  ALU result (rs1 + imm); destination node/neuron address.
- NET_WDATA  in  DATA_WIDTH  rs2 value for SWNET.
- NET_RDATA  out  DATA_WIDTH  LWNET result routed to the writeback mux (WB_MEM_READ_DATA).
- BUSYWAIT  out  1  pipeline stall request.
- TX_VALID  out  1  TX FIFO head valid.
- TX_READY  in  1  router accepts the head.
- TX_PACKET  out  32+DATA_WIDTH  {dest address, payload} at the TX head.
- RX_VALID  in  1  router offers a payload.
- RX_READY  out  1  RX FIFO can accept.
- RX_DATA  in  DATA_WIDTH  incoming payload.

## Operation
- Each FIFO is a circular buffer with a read pointer, a write pointer (log2(FIFO_DEPTH) bits, wrapping modulo depth) and an occupancy counter (log2(FIFO_DEPTH)+1 bits). full = (count == FIFO_DEPTH); empty = (count == 0).
- **SWNET** (NET_WRITE=1):
  - TX not full: push {NET_ADDR, NET_WDATA} at the edge, and BUSYWAIT=0 in that cycle.
  - TX full: BUSYWAIT=1, no push. The pipeline holds its inputs stable. Push happens on the first edge where TX is not full.
- **LWNET** (NET_READ=1):
  - RX not empty: NET_RDATA = RX head (combinational), BUSYWAIT=0, pop at the edge.
  - RX empty: BUSYWAIT=1. NET_RDATA is driven to 0 whenever RX is empty.
- **TX egress:**
  - TX_VALID = !empty and TX_PACKET = head.
  - Pop on TX_VALID & TX_READY.
  - TX_PACKET stays stable while TX_VALID=1 and TX_READY=0.
- **RX ingress:**
  - RX_READY = RESET & !full.
  - Push RX_DATA on RX_VALID & RX_READY.
- **Simultaneous push and pop** on the same FIFO: both happen, count unchanged, both pointers advance.
- **full/empty are taken from registered count only.** A TX push is refused in a cycle where TX is full even if a TX pop happens at the same edge. Likewise, LWNET against an empty RX waits even if RX_VALID=1 in that cycle. This keeps BUSYWAIT free of combinational paths from TX_READY/RX_VALID.
- **NET_WRITE and NET_READ both high** (illegal decode): the write is served and the read is ignored. BUSYWAIT reflects the write only.
- Neither request asserted: BUSYWAIT=0.

## Timing
- **Reset (RESET=0, async):**
  - Pointers and counts go to 0. FIFO contents are don't-care.
  - TX_VALID=0, RX_READY=0, BUSYWAIT=0, NET_RDATA=0.
  - Packets held in either FIFO are discarded; an in-progress stall is released immediately.
  - After deassertion, RX_READY=1 from the first cycle.
- **SWNET latency:**
  - TX not full: 0 stall cycles, and TX_VALID rises the cycle after the push edge.
  - TX full: stall lasts until one cycle after the first TX pop edge.
- **LWNET latency:**
  - RX not empty: 0 stall cycles.
  - RX empty: stall ends the cycle after the RX push edge, and the data is returned in that cycle.
- **Maximum throughput:** one push and one pop per FIFO per cycle.
- **Outputs:**
  - TX_VALID, TX_PACKET and RX_READY are functions of registered state only.
  - BUSYWAIT and NET_RDATA are combinational from registered state plus NET_WRITE/NET_READ.

## Test plan
- **Reset mid-stall:** fill TX (4 SWNETs, TX_READY=0), issue a 5th with BUSYWAIT=1, assert RESET for 1 cycle.
  - Required: BUSYWAIT=0 and TX_VALID=0 immediately; RX_READY=1 after release.
- **Single SWNET:** TX empty, TX_READY=1, NET_ADDR=0x00000105, NET_WDATA=0xDEADBEEF.
  - Required: BUSYWAIT=0; next cycle TX_VALID=1 with TX_PACKET=0x00000105_DEADBEEF; popped that edge; TX_VALID=0 after.
- **TX full backpressure:** TX_READY=0, 5 back-to-back SWNETs (data 1..5).
  - Required: first 4 accepted with no stall; 5th holds BUSYWAIT=1.
  - Raise TX_READY: packets leave in order 1,2,3,4,5, and BUSYWAIT drops the cycle after the first pop.
- **LWNET on empty RX:** issue LWNET, hold 3 cycles, then RX_VALID=1 with RX_DATA=0x3F800000 for one cycle.
  - Required: BUSYWAIT=1 through the push edge; next cycle BUSYWAIT=0 and NET_RDATA=0x3F800000; RX empty afterwards.
- **RX wrap-around and full:** push 4 words with no reads.
  - Required: RX_READY=0.
  - Then issue 6 LWNETs while pushing 0xA..0xF continuously as space frees; read order is strictly FIFO across the pointer wrap, with count never exceeding 4.
- **Simultaneous push/pop:** RX holding 2 entries, LWNET and RX_VALID in the same cycle.
  - Required: head returned, new word appended, count stays 2.
